// File: rtl/param_fifo.sv
// Synchronous FIFO with occupancy flags and per-cycle ack/err status; dout updates one edge after an accepted read.
// Writes into a full FIFO are refused with wr_err unless a read frees a slot in the same cycle; reads from empty give rd_err.
module param_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_AF    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_AE    = (ADDR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  wr_ok;
  logic                  rd_ok;

  // A write into a full FIFO still goes through when a read drains a slot on the same edge.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  assign full         = (data_count == CNT_DEPTH);
  assign empty        = (data_count == '0);
  assign almost_full  = (data_count >= CNT_AF);
  assign almost_empty = (data_count <= CNT_AE);

  always_comb begin
    count_nxt = data_count;
    if (wr_ok && !rd_ok) begin
      count_nxt = data_count + CNT_ONE;
    end else if (rd_ok && !wr_ok) begin
      count_nxt = data_count - CNT_ONE;
    end
  end

  // Storage is not reset; stale words are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (!reset && !flush && wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      dout       <= '0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        dout   <= mem[rd_ptr];
      end
      data_count <= count_nxt;
      wr_ack     <= wr_ok;
      wr_err     <= wr_en && !wr_ok;
      rd_ack     <= rd_ok;
      rd_err     <= rd_en && !rd_ok;
    end
  end

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: default 8x32 instance driven from a vector table, plus a 4x8 instance for wrap-around ordering.
module tb_param_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_wr_en, a_rd_en, a_flush;
  logic [31:0] a_din, a_dout;
  logic [3:0]  a_count;
  logic        a_full, a_empty, a_af, a_ae, a_wack, a_werr, a_rack, a_rerr;

  logic        b_wr_en, b_rd_en, b_flush;
  logic [7:0]  b_din, b_dout;
  logic [2:0]  b_count;
  logic        b_full, b_empty, b_af, b_ae, b_wack, b_werr, b_rack, b_rerr;

  param_fifo dut_a (
    .clk(clk), .reset(reset), .wr_en(a_wr_en), .din(a_din), .rd_en(a_rd_en), .flush(a_flush),
    .dout(a_dout), .data_count(a_count), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae),
    .wr_ack(a_wack), .wr_err(a_werr), .rd_ack(a_rack), .rd_err(a_rerr)
  );

  param_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(0)) dut_b (
    .clk(clk), .reset(reset), .wr_en(b_wr_en), .din(b_din), .rd_en(b_rd_en), .flush(b_flush),
    .dout(b_dout), .data_count(b_count), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae),
    .wr_ack(b_wack), .wr_err(b_werr), .rd_ack(b_rack), .rd_err(b_rerr)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr, rd, fl;
    logic [31:0] din;
    logic [31:0] dout;
    logic [3:0]  cnt;
    logic        full, empty, af, ae;
    logic        wack, werr, rack, rerr;
  } vec_t;

  vec_t vecs[$];

  // Flags for the default instance: DEPTH 8, AF_LEVEL 7, AE_LEVEL 1.
  function automatic vec_t mk(input logic wr, input logic rd, input logic fl, input logic [31:0] din,
                              input logic [31:0] dout, input int cnt,
                              input logic wack, input logic werr, input logic rack, input logic rerr);
    vec_t v;
    v.wr = wr; v.rd = rd; v.fl = fl; v.din = din;
    v.dout = dout; v.cnt = 4'(cnt);
    v.full = (cnt == 8); v.empty = (cnt == 0); v.af = (cnt >= 7); v.ae = (cnt <= 1);
    v.wack = wack; v.werr = werr; v.rack = rack; v.rerr = rerr;
    return v;
  endfunction

  task automatic chk_a_reset(input string tag);
    chk({tag, ".dout"},  a_dout,  0);
    chk({tag, ".count"}, a_count, 0);
    chk({tag, ".full"},  a_full,  0);
    chk({tag, ".empty"}, a_empty, 1);
    chk({tag, ".af"},    a_af,    0);
    chk({tag, ".ae"},    a_ae,    1);
    chk({tag, ".acks"},  {a_wack, a_werr, a_rack, a_rerr}, 0);
  endtask

  // Wrap-around model for the 4-deep instance.
  logic [7:0] bq[$];
  logic [7:0] b_exp_dout = 8'h00;
  int         b_cnt = 0;

  task automatic b_op(input logic wr, input logic rd, input logic [7:0] d, input int idx);
    logic ewa, ewe, era, ere;
    @(negedge clk);
    b_wr_en = wr; b_rd_en = rd; b_din = d;
    ewa = 1'b0; ewe = 1'b0; era = 1'b0; ere = 1'b0;
    if (rd) begin
      if (b_cnt > 0) begin
        b_exp_dout = bq.pop_front(); b_cnt--; era = 1'b1;
      end else begin
        ere = 1'b1;
      end
    end
    if (wr) begin
      if (b_cnt < 4) begin
        bq.push_back(d); b_cnt++; ewa = 1'b1;
      end else begin
        ewe = 1'b1;
      end
    end
    @(posedge clk); #1;
    chk($sformatf("b%0d.dout", idx),  b_dout,  b_exp_dout);
    chk($sformatf("b%0d.count", idx), b_count, b_cnt);
    chk($sformatf("b%0d.flags", idx), {b_full, b_empty, b_af, b_ae},
        {b_cnt == 4, b_cnt == 0, b_cnt >= 3, b_cnt == 0});
    chk($sformatf("b%0d.acks", idx),  {b_wack, b_werr, b_rack, b_rerr}, {ewa, ewe, era, ere});
  endtask

  initial begin
    reset = 1'b1;
    a_wr_en = 0; a_rd_en = 0; a_flush = 0; a_din = '0;
    b_wr_en = 0; b_rd_en = 0; b_flush = 0; b_din = '0;

    vecs.push_back(mk(0, 1, 0, 32'h0, 32'h0, 0, 0, 0, 0, 1));
    for (int k = 1; k <= 8; k++) vecs.push_back(mk(1, 0, 0, 32'(k), 32'h0, k, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'h9, 32'h0, 8, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 32'hA5A5A5A5, 32'h1, 8, 1, 0, 1, 0));
    for (int j = 2; j <= 8; j++) vecs.push_back(mk(0, 1, 0, 32'h0, 32'(j), 9 - j, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0, 32'hA5A5A5A5, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'hFFFF0000, 32'hA5A5A5A5, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0, 32'hFFFF0000, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 32'h11, 32'hFFFF0000, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'h22, 32'hFFFF0000, 2, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'h33, 32'hFFFF0000, 3, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 32'h44, 32'hFFFF0000, 0, 0, 0, 0, 0));

    #2;
    chk_a_reset("rst");
    chk("rst.b_count", b_count, 0);
    chk("rst.b_empty", b_empty, 1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      a_wr_en = vecs[i].wr; a_rd_en = vecs[i].rd; a_flush = vecs[i].fl; a_din = vecs[i].din;
      @(posedge clk); #1;
      chk($sformatf("v%0d.dout", i),  a_dout,  vecs[i].dout);
      chk($sformatf("v%0d.count", i), a_count, vecs[i].cnt);
      chk($sformatf("v%0d.flags", i), {a_full, a_empty, a_af, a_ae},
          {vecs[i].full, vecs[i].empty, vecs[i].af, vecs[i].ae});
      chk($sformatf("v%0d.acks", i),  {a_wack, a_werr, a_rack, a_rerr},
          {vecs[i].wack, vecs[i].werr, vecs[i].rack, vecs[i].rerr});
    end

    // Asynchronous reset in the middle of a clock period, with a word stored and wr_ack high.
    @(negedge clk);
    a_wr_en = 1; a_rd_en = 0; a_flush = 0; a_din = 32'h55;
    @(posedge clk); #1;
    chk("pre_rst.count", a_count, 1);
    chk("pre_rst.wack",  a_wack,  1);
    #1;
    a_wr_en = 0;
    reset = 1'b1;
    #1;
    chk_a_reset("mid_rst");
    #2;
    reset = 1'b0;

    @(negedge clk);
    a_wr_en = 1; a_din = 32'h66;
    @(posedge clk); #1;
    chk("post_rst.wr_count", a_count, 1);
    chk("post_rst.wack",     a_wack,  1);
    @(negedge clk);
    a_wr_en = 0; a_rd_en = 1;
    @(posedge clk); #1;
    chk("post_rst.dout",  a_dout,  32'h66);
    chk("post_rst.count", a_count, 0);
    @(negedge clk);
    a_rd_en = 0;

    for (int i = 0; i < 12; i++) begin
      b_op(1'b1, 1'b0, 8'(i * 37 + 5), 2 * i);
      if (i >= 2) b_op(1'b0, 1'b1, 8'h00, 2 * i + 1);
    end
    for (int i = 0; i < 4; i++) b_op(1'b0, 1'b1, 8'h00, 100 + i);
    @(negedge clk);
    b_wr_en = 0; b_rd_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
